datapath_control_unit: RTL and testbench

//  Hard-wired Mini-SRC control sequencer for the bus datapath (main1).

---
 rtl/mini_src_pkg.sv | 116 +++++++++++
 rtl/control_step_decode.sv | 192 +++++++++++++++++++
 rtl/datapath_control_unit.sv | 131 +++++++++++++
 tb/tb_datapath_control_unit.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini_src_pkg.sv
// Shared Mini-SRC encodings: opcodes, ALU codes, T-step codes and the control strobe bundle.
package mini_src_pkg;

   localparam int unsigned OP_W   = 5;
   localparam int unsigned ALU_W  = 4;
   localparam int unsigned STEP_W = 4;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_PASS  = 4'b0000;
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_SUB   = 4'b0010;
   localparam logic [3:0] ALU_AND   = 4'b0011;
   localparam logic [3:0] ALU_OR    = 4'b0100;
   localparam logic [3:0] ALU_ROR   = 4'b0101;
   localparam logic [3:0] ALU_ROL   = 4'b0110;
   localparam logic [3:0] ALU_SHR   = 4'b0111;
   localparam logic [3:0] ALU_SHRA  = 4'b1000;
   localparam logic [3:0] ALU_INCPC = 4'b1001;
   localparam logic [3:0] ALU_SHL   = 4'b1010;
   localparam logic [3:0] ALU_MUL   = 4'b1011;
   localparam logic [3:0] ALU_DIV   = 4'b1100;
   localparam logic [3:0] ALU_NEG   = 4'b1101;
   localparam logic [3:0] ALU_NOT   = 4'b1110;

   localparam logic [3:0] STEP_T0   = 4'd0;
   localparam logic [3:0] STEP_T1   = 4'd1;
   localparam logic [3:0] STEP_T2   = 4'd2;
   localparam logic [3:0] STEP_T3   = 4'd3;
   localparam logic [3:0] STEP_T4   = 4'd4;
   localparam logic [3:0] STEP_T5   = 4'd5;
   localparam logic [3:0] STEP_T6   = 4'd6;
   localparam logic [3:0] STEP_T7   = 4'd7;
   localparam logic [3:0] STEP_HALT = 4'd8;

   typedef struct packed {
      logic gra;
      logic grb;
      logic grc;
      logic rin;
      logic rout;
      logic ba_out;
      logic c_out;
      logic pc_out;
      logic pc_in;
      logic inc_pc;
      logic mar_in;
      logic mdr_in;
      logic mdr_out;
      logic read;
      logic write;
      logic ir_in;
      logic y_in;
      logic z_in;
      logic zlow_out;
      logic zhigh_out;
      logic hi_in;
      logic hi_out;
      logic lo_in;
      logic lo_out;
      logic inport_out;
      logic outport_in;
      logic con_in;
   } ctrl_t;

   // ALU operation for the opcodes that compute through Z; PASS for everything else.
   function automatic logic [3:0] alu_code(input logic [4:0] op);
      logic [3:0] code;
      code = ALU_PASS;
      case (op)
         OP_ADD, OP_ADDI: code = ALU_ADD;
         OP_SUB:          code = ALU_SUB;
         OP_AND, OP_ANDI: code = ALU_AND;
         OP_OR, OP_ORI:   code = ALU_OR;
         OP_ROR:          code = ALU_ROR;
         OP_ROL:          code = ALU_ROL;
         OP_SHR:          code = ALU_SHR;
         OP_SHRA:         code = ALU_SHRA;
         OP_SHL:          code = ALU_SHL;
         OP_MUL:          code = ALU_MUL;
         OP_DIV:          code = ALU_DIV;
         OP_NEG:          code = ALU_NEG;
         OP_NOT:          code = ALU_NOT;
         default:         code = ALU_PASS;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational strobe decode for one T-step of the current instruction.
module control_step_decode
   import mini_src_pkg::*;
(
   input  logic [STEP_W-1:0] step,
   input  logic [OP_W-1:0]   opcode,
   input  logic              con_ff,
   output ctrl_t             ctrl_c,
   output logic [ALU_W-1:0]  alu_sel_c,
   output logic              last_step_c,
   output logic              mem_step_c
);

   logic is_mem_ref, is_alu3, is_imm, is_md, is_un;
   logic is_single, has_exec;

   assign is_mem_ref = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
   assign is_alu3    = (opcode >= OP_ADD) && (opcode <= OP_SHL);
   assign is_imm     = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
   assign is_md      = (opcode == OP_MUL) || (opcode == OP_DIV);
   assign is_un      = (opcode == OP_NEG) || (opcode == OP_NOT);
   assign is_single  = (opcode == OP_JR) || (opcode == OP_IN) || (opcode == OP_OUT) ||
                       (opcode == OP_MFHI) || (opcode == OP_MFLO);
   assign has_exec   = is_mem_ref || is_alu3 || is_imm || is_md || is_un ||
                       (opcode == OP_BR) || is_single;

   // Steps an opcode does not define terminate the instruction with all strobes low.
   always_comb begin
      ctrl_c      = '0;
      alu_sel_c   = ALU_PASS;
      last_step_c = 1'b0;
      mem_step_c  = 1'b0;
      case (step)
         STEP_T0: begin
            ctrl_c.pc_out = 1'b1;
            ctrl_c.mar_in = 1'b1;
            ctrl_c.inc_pc = 1'b1;
            ctrl_c.z_in   = 1'b1;
            alu_sel_c     = ALU_INCPC;
         end
         STEP_T1: begin
            ctrl_c.zlow_out = 1'b1;
            ctrl_c.pc_in    = 1'b1;
            ctrl_c.read     = 1'b1;
            ctrl_c.mdr_in   = 1'b1;
            mem_step_c      = 1'b1;
         end
         STEP_T2: begin
            ctrl_c.mdr_out = 1'b1;
            ctrl_c.ir_in   = 1'b1;
            last_step_c    = !has_exec;
         end
         STEP_T3: begin
            if (is_mem_ref) begin
               ctrl_c.grb    = 1'b1;
               ctrl_c.ba_out = 1'b1;
               ctrl_c.y_in   = 1'b1;
            end else if (is_alu3 || is_imm) begin
               ctrl_c.grb  = 1'b1;
               ctrl_c.rout = 1'b1;
               ctrl_c.y_in = 1'b1;
            end else if (is_md) begin
               ctrl_c.gra  = 1'b1;
               ctrl_c.rout = 1'b1;
               ctrl_c.y_in = 1'b1;
            end else if (is_un) begin
               ctrl_c.grb  = 1'b1;
               ctrl_c.rout = 1'b1;
               ctrl_c.z_in = 1'b1;
               alu_sel_c   = alu_code(opcode);
            end else if (opcode == OP_BR) begin
               ctrl_c.gra    = 1'b1;
               ctrl_c.rout   = 1'b1;
               ctrl_c.con_in = 1'b1;
            end else if (opcode == OP_JR) begin
               ctrl_c.gra   = 1'b1;
               ctrl_c.rout  = 1'b1;
               ctrl_c.pc_in = 1'b1;
               last_step_c  = 1'b1;
            end else if (opcode == OP_IN) begin
               ctrl_c.inport_out = 1'b1;
               ctrl_c.gra        = 1'b1;
               ctrl_c.rin        = 1'b1;
               last_step_c       = 1'b1;
            end else if (opcode == OP_OUT) begin
               ctrl_c.gra        = 1'b1;
               ctrl_c.rout       = 1'b1;
               ctrl_c.outport_in = 1'b1;
               last_step_c       = 1'b1;
            end else if (opcode == OP_MFHI) begin
               ctrl_c.hi_out = 1'b1;
               ctrl_c.gra    = 1'b1;
               ctrl_c.rin    = 1'b1;
               last_step_c   = 1'b1;
            end else if (opcode == OP_MFLO) begin
               ctrl_c.lo_out = 1'b1;
               ctrl_c.gra    = 1'b1;
               ctrl_c.rin    = 1'b1;
               last_step_c   = 1'b1;
            end else begin
               last_step_c = 1'b1;
            end
         end
         STEP_T4: begin
            if (is_mem_ref) begin
               ctrl_c.c_out = 1'b1;
               ctrl_c.z_in  = 1'b1;
               alu_sel_c    = ALU_ADD;
            end else if (is_alu3) begin
               ctrl_c.grc  = 1'b1;
               ctrl_c.rout = 1'b1;
               ctrl_c.z_in = 1'b1;
               alu_sel_c   = alu_code(opcode);
            end else if (is_imm) begin
               ctrl_c.c_out = 1'b1;
               ctrl_c.z_in  = 1'b1;
               alu_sel_c    = alu_code(opcode);
            end else if (is_md) begin
               ctrl_c.grb  = 1'b1;
               ctrl_c.rout = 1'b1;
               ctrl_c.z_in = 1'b1;
               alu_sel_c   = alu_code(opcode);
            end else if (is_un) begin
               ctrl_c.zlow_out = 1'b1;
               ctrl_c.gra      = 1'b1;
               ctrl_c.rin      = 1'b1;
               last_step_c     = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl_c.pc_out = 1'b1;
               ctrl_c.y_in   = 1'b1;
            end else begin
               last_step_c = 1'b1;
            end
         end
         STEP_T5: begin
            if ((opcode == OP_LD) || (opcode == OP_ST)) begin
               ctrl_c.zlow_out = 1'b1;
               ctrl_c.mar_in   = 1'b1;
            end else if ((opcode == OP_LDI) || is_alu3 || is_imm) begin
               ctrl_c.zlow_out = 1'b1;
               ctrl_c.gra      = 1'b1;
               ctrl_c.rin      = 1'b1;
               last_step_c     = 1'b1;
            end else if (is_md) begin
               ctrl_c.zlow_out = 1'b1;
               ctrl_c.lo_in    = 1'b1;
            end else if (opcode == OP_BR) begin
               ctrl_c.c_out = 1'b1;
               ctrl_c.z_in  = 1'b1;
               alu_sel_c    = ALU_ADD;
            end else begin
               last_step_c = 1'b1;
            end
         end
         STEP_T6: begin
            last_step_c = 1'b1;
            if (opcode == OP_LD) begin
               ctrl_c.read   = 1'b1;
               ctrl_c.mdr_in = 1'b1;
               mem_step_c    = 1'b1;
               last_step_c   = 1'b1 & 1'b0;
            end else if (opcode == OP_ST) begin
               ctrl_c.gra    = 1'b1;
               ctrl_c.rout   = 1'b1;
               ctrl_c.mdr_in = 1'b1;
               last_step_c   = 1'b0;
            end else if (is_md) begin
               ctrl_c.zhigh_out = 1'b1;
               ctrl_c.hi_in     = 1'b1;
            end else if ((opcode == OP_BR) && con_ff) begin
               ctrl_c.zlow_out = 1'b1;
               ctrl_c.pc_in    = 1'b1;
            end
         end
         STEP_T7: begin
            last_step_c = 1'b1;
            if (opcode == OP_LD) begin
               ctrl_c.mdr_out = 1'b1;
               ctrl_c.gra     = 1'b1;
               ctrl_c.rin     = 1'b1;
            end else if (opcode == OP_ST) begin
               ctrl_c.write = 1'b1;
               mem_step_c   = 1'b1;
            end
         end
         default: begin
            last_step_c = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/datapath_control_unit.sv
// Hard-wired Mini-SRC sequencer: one T-step per clock, fetch/decode/execute, memory wait and halt.
module datapath_control_unit
   import mini_src_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      IR,
   input  logic             con_ff,
   input  logic             mem_ready,
   output logic             Gra,
   output logic             Grb,
   output logic             Grc,
   output logic             Rin,
   output logic             Rout,
   output logic             BAout,
   output logic             Cout,
   output logic             PCout,
   output logic             PCin,
   output logic             IncPC,
   output logic             MARin,
   output logic             MDRin,
   output logic             MDRout,
   output logic             Read,
   output logic             Write,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             ZLowout,
   output logic             ZHighout,
   output logic             HIin,
   output logic             HIout,
   output logic             LOin,
   output logic             LOout,
   output logic             InPortout,
   output logic             outPortin,
   output logic             conIn,
   output logic [ALU_W-1:0] ALUselect,
   output logic             run
);

   logic [STEP_W-1:0] step_q, step_d;
   logic              run_q, run_d;
   logic [OP_W-1:0]   opcode;
   ctrl_t             dec_ctrl, ctrl;
   logic [ALU_W-1:0]  dec_alu, alu_sel;
   logic              dec_last, dec_mem;
   logic              ir_unused_c;

   assign opcode      = IR[31:27];
   assign ir_unused_c = ^IR[26:0];

   control_step_decode u_decode (
      .step        (step_q),
      .opcode      (opcode),
      .con_ff      (con_ff),
      .ctrl_c      (dec_ctrl),
      .alu_sel_c   (dec_alu),
      .last_step_c (dec_last),
      .mem_step_c  (dec_mem)
   );

   // run_q low after reset holds T0 idle for one cycle, so the first real T0 follows release.
   always_comb begin
      step_d = step_q;
      if (step_q == STEP_HALT) begin
         step_d = STEP_HALT;
      end else if (!run_q) begin
         step_d = STEP_T0;
      end else if (dec_mem && !mem_ready) begin
         step_d = step_q;
      end else if ((step_q == STEP_T2) && (opcode == OP_HALT)) begin
         step_d = STEP_HALT;
      end else if (dec_last) begin
         step_d = STEP_T0;
      end else begin
         step_d = step_q + STEP_W'(1);
      end
      run_d = (step_d != STEP_HALT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_q <= STEP_T0;
         run_q  <= 1'b0;
      end else begin
         step_q <= step_d;
         run_q  <= run_d;
      end
   end

   // Strobes are silent whenever the sequencer is not running (reset idle or halted).
   always_comb begin
      ctrl    = '0;
      alu_sel = ALU_PASS;
      if (run_q) begin
         ctrl    = dec_ctrl;
         alu_sel = dec_alu;
      end
   end

   assign Gra       = ctrl.gra;
   assign Grb       = ctrl.grb;
   assign Grc       = ctrl.grc;
   assign Rin       = ctrl.rin;
   assign Rout      = ctrl.rout;
   assign BAout     = ctrl.ba_out;
   assign Cout      = ctrl.c_out;
   assign PCout     = ctrl.pc_out;
   assign PCin      = ctrl.pc_in;
   assign IncPC     = ctrl.inc_pc;
   assign MARin     = ctrl.mar_in;
   assign MDRin     = ctrl.mdr_in;
   assign MDRout    = ctrl.mdr_out;
   assign Read      = ctrl.read;
   assign Write     = ctrl.write;
   assign IRin      = ctrl.ir_in;
   assign Yin       = ctrl.y_in;
   assign Zin       = ctrl.z_in;
   assign ZLowout   = ctrl.zlow_out;
   assign ZHighout  = ctrl.zhigh_out;
   assign HIin      = ctrl.hi_in;
   assign HIout     = ctrl.hi_out;
   assign LOin      = ctrl.lo_in;
   assign LOout     = ctrl.lo_out;
   assign InPortout = ctrl.inport_out;
   assign outPortin = ctrl.outport_in;
   assign conIn     = ctrl.con_in;
   assign ALUselect = alu_sel;
   assign run       = run_q;

endmodule

// File: tb/tb_datapath_control_unit.sv
// Scoreboard bench: per-instruction step table model feeds an expected queue; a negedge monitor checks.
module tb_datapath_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IR;
   logic        con_ff, mem_ready;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin;
   logic Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin, LOout;
   logic InPortout, outPortin, conIn;
   logic [3:0] ALUselect;
   logic run;

   always #5 clk = ~clk;

   datapath_control_unit dut (
      .clk(clk), .rst_n(rst_n), .IR(IR), .con_ff(con_ff), .mem_ready(mem_ready),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin),
      .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
      .HIout(HIout), .LOin(LOin), .LOout(LOout),
      .InPortout(InPortout), .outPortin(outPortin), .conIn(conIn),
      .ALUselect(ALUselect), .run(run)
   );

   logic [26:0] act;
   assign act = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin,
                 MDRout, Read, Write, IRin, Yin, Zin, ZLowout, ZHighout, HIin, HIout, LOin,
                 LOout, InPortout, outPortin, conIn};

   localparam logic [26:0] M_GRA = 27'(1) << 26, M_GRB = 27'(1) << 25, M_GRC = 27'(1) << 24;
   localparam logic [26:0] M_RIN = 27'(1) << 23, M_ROUT = 27'(1) << 22, M_BAOUT = 27'(1) << 21;
   localparam logic [26:0] M_COUT = 27'(1) << 20, M_PCOUT = 27'(1) << 19, M_PCIN = 27'(1) << 18;
   localparam logic [26:0] M_INCPC = 27'(1) << 17, M_MARIN = 27'(1) << 16, M_MDRIN = 27'(1) << 15;
   localparam logic [26:0] M_MDROUT = 27'(1) << 14, M_READ = 27'(1) << 13, M_WRITE = 27'(1) << 12;
   localparam logic [26:0] M_IRIN = 27'(1) << 11, M_YIN = 27'(1) << 10, M_ZIN = 27'(1) << 9;
   localparam logic [26:0] M_ZLO = 27'(1) << 8, M_ZHI = 27'(1) << 7, M_HIIN = 27'(1) << 6;
   localparam logic [26:0] M_HIOUT = 27'(1) << 5, M_LOIN = 27'(1) << 4, M_LOOUT = 27'(1) << 3;
   localparam logic [26:0] M_INP = 27'(1) << 2, M_OUTP = 27'(1) << 1, M_CONIN = 27'(1);

   typedef struct {
      logic [26:0] mask;
      logic [3:0]  alu;
      logic        mem;
      logic        cond;
   } step_t;

   typedef struct {
      logic [26:0] s;
      logic [3:0]  alu;
      logic        run;
   } exp_t;

   step_t plan_q[$];
   exp_t  exp_q[$];
   exp_t  mon_e;
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;

   function automatic void add_step(input logic [26:0] m, input logic [3:0] a,
                                    input logic mem, input logic cond);
      step_t s;
      s.mask = m; s.alu = a; s.mem = mem; s.cond = cond;
      plan_q.push_back(s);
   endfunction

   function automatic logic [3:0] op_alu(input logic [4:0] op);
      case (op)
         5'd3, 5'd12: return 4'd1;
         5'd4:        return 4'd2;
         5'd5, 5'd13: return 4'd3;
         5'd6, 5'd14: return 4'd4;
         5'd7:        return 4'd5;
         5'd8:        return 4'd6;
         5'd9:        return 4'd7;
         5'd10:       return 4'd8;
         5'd11:       return 4'd10;
         5'd15:       return 4'd11;
         5'd16:       return 4'd12;
         5'd17:       return 4'd13;
         5'd18:       return 4'd14;
         default:     return 4'd0;
      endcase
   endfunction

   // Builds the T-step table of one instruction; returns 1 when the instruction halts.
   function automatic logic plan_instr(input logic [4:0] op);
      logic [3:0] a;
      a = op_alu(op);
      plan_q.delete();
      add_step(M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 4'd9, 1'b0, 1'b0);
      add_step(M_ZLO | M_PCIN | M_READ | M_MDRIN, 4'd0, 1'b1, 1'b0);
      add_step(M_MDROUT | M_IRIN, 4'd0, 1'b0, 1'b0);
      case (op)
         5'd0: begin
            add_step(M_GRB | M_BAOUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_COUT | M_ZIN, 4'd1, 1'b0, 1'b0);
            add_step(M_ZLO | M_MARIN, 4'd0, 1'b0, 1'b0);
            add_step(M_READ | M_MDRIN, 4'd0, 1'b1, 1'b0);
            add_step(M_MDROUT | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         end
         5'd1: begin
            add_step(M_GRB | M_BAOUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_COUT | M_ZIN, 4'd1, 1'b0, 1'b0);
            add_step(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         end
         5'd2: begin
            add_step(M_GRB | M_BAOUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_COUT | M_ZIN, 4'd1, 1'b0, 1'b0);
            add_step(M_ZLO | M_MARIN, 4'd0, 1'b0, 1'b0);
            add_step(M_GRA | M_ROUT | M_MDRIN, 4'd0, 1'b0, 1'b0);
            add_step(M_WRITE, 4'd0, 1'b1, 1'b0);
         end
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
            add_step(M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_GRC | M_ROUT | M_ZIN, a, 1'b0, 1'b0);
            add_step(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         end
         5'd12, 5'd13, 5'd14: begin
            add_step(M_GRB | M_ROUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_COUT | M_ZIN, a, 1'b0, 1'b0);
            add_step(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         end
         5'd15, 5'd16: begin
            add_step(M_GRA | M_ROUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_GRB | M_ROUT | M_ZIN, a, 1'b0, 1'b0);
            add_step(M_ZLO | M_LOIN, 4'd0, 1'b0, 1'b0);
            add_step(M_ZHI | M_HIIN, 4'd0, 1'b0, 1'b0);
         end
         5'd17, 5'd18: begin
            add_step(M_GRB | M_ROUT | M_ZIN, a, 1'b0, 1'b0);
            add_step(M_ZLO | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         end
         5'd19: begin
            add_step(M_GRA | M_ROUT | M_CONIN, 4'd0, 1'b0, 1'b0);
            add_step(M_PCOUT | M_YIN, 4'd0, 1'b0, 1'b0);
            add_step(M_COUT | M_ZIN, 4'd1, 1'b0, 1'b0);
            add_step(M_ZLO | M_PCIN, 4'd0, 1'b0, 1'b1);
         end
         5'd20: add_step(M_GRA | M_ROUT | M_PCIN, 4'd0, 1'b0, 1'b0);
         5'd22: add_step(M_INP | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         5'd23: add_step(M_GRA | M_ROUT | M_OUTP, 4'd0, 1'b0, 1'b0);
         5'd24: add_step(M_HIOUT | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         5'd25: add_step(M_LOOUT | M_GRA | M_RIN, 4'd0, 1'b0, 1'b0);
         5'd27: return 1'b1;
         default: ;
      endcase
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [26:0] s, input logic [3:0] a, input logic r);
      exp_t e;
      e.s = s; e.alu = a; e.run = r;
      exp_q.push_back(e);
   endtask

   // waits: forced low cycles at each memory step (-1 random); con_mode: -1 random, else fixed.
   task automatic run_instr(input logic [31:0] ir, input int waits, input int abort_at,
                            input int con_mode);
      logic  halted;
      logic  mr;
      step_t p;
      int    w;
      halted = plan_instr(ir[31:27]);
      for (int i = 0; i < plan_q.size(); i++) begin
         p = plan_q[i];
         w = 0;
         forever begin
            tick();
            if (i == 0) IR = ir;
            con_ff = (con_mode < 0) ? 1'($urandom) : 1'(con_mode);
            if (!p.mem)        mr = 1'($urandom);
            else if (waits >= 0) mr = (w >= waits);
            else               mr = (w >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
            if (i == abort_at) begin
               if (p.mem) mr = 1'b0;
               rst_n = 1'b0;
            end
            mem_ready = mr;
            push((p.cond && !con_ff) ? 27'd0 : p.mask, p.alu, 1'b1);
            if (i == abort_at) begin
               tick();
               rst_n = 1'b1;
               push(27'd0, 4'd0, 1'b0);
               return;
            end
            if (p.mem && !mr) w++;
            else break;
         end
      end
      if (halted) begin
         repeat (20) begin
            tick();
            mem_ready = 1'($urandom);
            con_ff    = 1'($urandom);
            push(27'd0, 4'd0, 1'b0);
         end
         tick();
         rst_n = 1'b0;
         push(27'd0, 4'd0, 1'b0);
         tick();
         rst_n = 1'b1;
         push(27'd0, 4'd0, 1'b0);
      end
   endtask

   task automatic random_instrs(input int n);
      logic [4:0] op;
      for (int k = 0; k < n; k++) begin
         op = 5'($urandom_range(0, 31));
         if (op == 5'd27) op = 5'd26;
         run_instr({op, 27'($urandom)}, -1, -1, -1);
      end
   endtask

   always @(negedge clk) begin
      cyc++;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         total++;
         if (act !== mon_e.s || ALUselect !== mon_e.alu || run !== mon_e.run) begin
            bad++;
            $display("FAIL cycle %0d outputs: strobes got=%07h exp=%07h alu got=%h exp=%h run got=%b exp=%b",
                     cyc, act, mon_e.s, ALUselect, mon_e.alu, run, mon_e.run);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; IR = 32'd0; con_ff = 1'b0; mem_ready = 1'b0;
      tick(); push(27'd0, 4'd0, 1'b0);
      tick(); push(27'd0, 4'd0, 1'b0);
      tick(); rst_n = 1'b1; push(27'd0, 4'd0, 1'b0);
      run_instr(32'h00800055, 0, -1, -1);
      run_instr(32'h19890000, 0, -1, -1);
      run_instr(32'h98800000, 0, -1, 0);
      run_instr(32'h98800000, 0, -1, 1);
      run_instr(32'h08800000, 3, -1, -1);
      run_instr(32'h00800055, 3, -1, -1);
      random_instrs(80);
      run_instr(32'h00800055, 0, 4, -1);
      run_instr(32'h00800055, -1, 6, -1);
      run_instr(32'h19890000, -1, -1, -1);
      run_instr(32'hD8000000, -1, -1, -1);
      random_instrs(25);
      @(negedge clk);
      #1;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending got=%0d exp=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
